// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// PwmCapture (module pwm_capture)
//
// Purpose:
//   Read-back monitor for the photonic-switch PWM line. It measures each
//   complete PWM cycle in core-clock cycles and reports the high time and the
//   rising-to-rising period with a one-cycle valid strobe. A line that stays
//   stuck high or stuck low is reported with a one-cycle timeout strobe,
//   together with the level the line was stuck at.
//
// Ports:
//   clk         - core clock
//   reset       - synchronous, active-high reset
//   en          - measurement enable; dropping it abandons any partial period
//   pwm_in      - PWM line under test, may be asynchronous to clk
//   high_cnt    - cycles the line was high in the last complete period
//   period_cnt  - cycles from one rising edge to the next
//   valid       - one-cycle strobe when high_cnt/period_cnt update
//   timeout     - one-cycle strobe when no expected edge arrives in time
//   stuck_level - synchronized line level captured when timeout fired
//   busy        - high while a period is being measured
// ---------------------------------------------------------------------------
module pwm_capture #(
    parameter int          CW      = 16,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          pwm_in,
    output logic [CW-1:0] high_cnt,
    output logic [CW-1:0] period_cnt,
    output logic          valid,
    output logic          timeout,
    output logic          stuck_level,
    output logic          busy
);

    localparam logic [CW-1:0] TimeoutVal = CW'(TIMEOUT);
    localparam logic [CW-1:0] CountOne   = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS_HIGH,
        MEAS_LOW
    } state_t;

    state_t        state_q;

    logic          pwmMeta_q;
    logic          pwmS_q;
    logic          pwmD_q;
    logic          rise;
    logic          fall;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] hiTmp_q;
    logic [CW-1:0] idleCnt_q;
    logic [CW-1:0] idleCnt_d;
    logic          cntExpired;
    logic          idleExpired;

    logic [CW-1:0] highCnt_q;
    logic [CW-1:0] periodCnt_q;
    logic          valid_q;
    logic          timeout_q;
    logic          stuckLevel_q;

    // Two flops bring the asynchronous line into the clock domain; the third
    // flop gives the previous synchronized sample so both edges are detected
    // with the same latency, which keeps the measured widths unbiased.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwmMeta_q <= 1'b0;
            pwmS_q    <= 1'b0;
            pwmD_q    <= 1'b0;
        end else begin
            pwmMeta_q <= pwm_in;
            pwmS_q    <= pwmMeta_q;
            pwmD_q    <= pwmS_q;
        end
    end

    // Edge strobes on the synchronized line, each high for exactly one cycle.
    always_comb begin
        rise = pwmS_q & ~pwmD_q;
        fall = ~pwmS_q & pwmD_q;
    end

    // Next values of the two counters. They saturate at all-ones so that a
    // timeout threshold at the very top of the range can never be skipped by
    // a wrap; with a legal threshold the compare fires long before that.
    always_comb begin
        cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + CountOne;
        idleCnt_d   = (idleCnt_q == '1) ? idleCnt_q : idleCnt_q + CountOne;
        cntExpired  = (cnt_q >= TimeoutVal);
        idleExpired = (idleCnt_q >= TimeoutVal);
    end

    // Measurement state machine with registered outputs.
    //  - cnt is loaded with 1 on the cycle a rise is seen, so on the cycle the
    //    matching fall is seen it already equals the high time, and on the
    //    cycle the next rise is seen it equals the full period.
    //  - The expected edge always has priority over the timeout compare.
    //  - Entering ARM loads the idle counter with 1, so it counts ARM cycles
    //    including the current one; this makes repeated timeouts on a stuck
    //    line exactly TIMEOUT cycles apart.
    //  - Timeouts never touch high_cnt/period_cnt.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hiTmp_q      <= '0;
            idleCnt_q    <= '0;
            highCnt_q    <= '0;
            periodCnt_q  <= '0;
            valid_q      <= 1'b0;
            timeout_q    <= 1'b0;
            stuckLevel_q <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    cnt_q     <= '0;
                    hiTmp_q   <= '0;
                    idleCnt_q <= '0;
                    if (en) begin
                        state_q   <= ARM;
                        idleCnt_q <= CountOne;
                    end
                end

                ARM: begin
                    if (!en) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        hiTmp_q   <= '0;
                        idleCnt_q <= '0;
                    end else if (rise) begin
                        state_q   <= MEAS_HIGH;
                        cnt_q     <= CountOne;
                        hiTmp_q   <= '0;
                        idleCnt_q <= '0;
                    end else if (idleExpired) begin
                        timeout_q    <= 1'b1;
                        stuckLevel_q <= pwmS_q;
                        idleCnt_q    <= CountOne;
                    end else begin
                        idleCnt_q <= idleCnt_d;
                    end
                end

                MEAS_HIGH: begin
                    if (!en) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        hiTmp_q   <= '0;
                        idleCnt_q <= '0;
                    end else if (fall) begin
                        state_q <= MEAS_LOW;
                        hiTmp_q <= cnt_q;
                        cnt_q   <= cnt_d;
                    end else if (cntExpired) begin
                        state_q      <= ARM;
                        timeout_q    <= 1'b1;
                        stuckLevel_q <= pwmS_q;
                        cnt_q        <= '0;
                        hiTmp_q      <= '0;
                        idleCnt_q    <= CountOne;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                MEAS_LOW: begin
                    if (!en) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        hiTmp_q   <= '0;
                        idleCnt_q <= '0;
                    end else if (rise) begin
                        // The rise that closes this period also opens the
                        // next one, so back-to-back periods have no gap.
                        state_q     <= MEAS_HIGH;
                        periodCnt_q <= cnt_q;
                        highCnt_q   <= hiTmp_q;
                        valid_q     <= 1'b1;
                        cnt_q       <= CountOne;
                        hiTmp_q     <= '0;
                    end else if (cntExpired) begin
                        state_q      <= ARM;
                        timeout_q    <= 1'b1;
                        stuckLevel_q <= pwmS_q;
                        cnt_q        <= '0;
                        hiTmp_q      <= '0;
                        idleCnt_q    <= CountOne;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                default: begin
                    state_q   <= IDLE;
                    cnt_q     <= '0;
                    hiTmp_q   <= '0;
                    idleCnt_q <= '0;
                end
            endcase
        end
    end

    // Output drive; busy is decoded straight from the state register.
    always_comb begin
        high_cnt    = highCnt_q;
        period_cnt  = periodCnt_q;
        valid       = valid_q;
        timeout     = timeout_q;
        stuck_level = stuckLevel_q;
        busy        = (state_q == MEAS_HIGH) || (state_q == MEAS_LOW);
    end

endmodule
